ps2_text_cursor: RTL and testbench

Upstream stage of the VGA text terminal. Receives raw PS/2 keyboard frames, decodes set-2 scan codes into ASCII, and tracks the 30×70 character-grid cursor. Emits one-cycle character-write commands (row, column, code) for the screen character RAM, plus the live cursor position the display uses for the inverted-cell marker.

---
 rtl/ps2_text_cursor_if.sv | 31 +++
 rtl/ps2_text_cursor.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_ps2_text_cursor.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_text_cursor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ps2_text_cursor_if                                               |
// | Brief   : Raw PS/2 inputs and character-RAM / cursor outputs of the        |
// |           keyboard front end of the text terminal.                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface ps2_text_cursor_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       wr_en;
  logic [4:0] wr_row;
  logic [6:0] wr_col;
  logic [7:0] wr_char;
  logic [4:0] cur_row;
  logic [6:0] cur_col;
  logic       caps;
  logic       frame_err;

  // master: the cursor block, which consumes the keyboard and drives the screen side
  modport master (
    input  ps2_clk, ps2_data,
    output wr_en, wr_row, wr_col, wr_char, cur_row, cur_col, caps, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  wr_en, wr_row, wr_col, wr_char, cur_row, cur_col, caps, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/ps2_text_cursor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ps2_text_cursor                                                  |
// | Brief   : PS/2 frame receiver, set-2 to ASCII decoder and text-grid cursor |
// |           producing one-cycle character-RAM write commands.               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ps2_text_cursor #(
  parameter int ROWS    = 30,
  parameter int COLS    = 70,
  parameter int TIMEOUT = 50000
) (
  input  logic               clk,
  input  logic               reset,
  ps2_text_cursor_if.master  bus
);

  localparam int               c_IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_IDLE_W-1:0] c_TIMEOUT = c_IDLE_W'(TIMEOUT);
  localparam logic [4:0]       c_LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0]       c_LAST_COL = 7'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  // {hit, letter index 0..25}
  function automatic logic [5:0] letter_lookup(input logic [7:0] code);
    case (code)
      8'h1C: return {1'b1, 5'd0};   8'h32: return {1'b1, 5'd1};
      8'h21: return {1'b1, 5'd2};   8'h23: return {1'b1, 5'd3};
      8'h24: return {1'b1, 5'd4};   8'h2B: return {1'b1, 5'd5};
      8'h34: return {1'b1, 5'd6};   8'h33: return {1'b1, 5'd7};
      8'h43: return {1'b1, 5'd8};   8'h3B: return {1'b1, 5'd9};
      8'h42: return {1'b1, 5'd10};  8'h4B: return {1'b1, 5'd11};
      8'h3A: return {1'b1, 5'd12};  8'h31: return {1'b1, 5'd13};
      8'h44: return {1'b1, 5'd14};  8'h4D: return {1'b1, 5'd15};
      8'h15: return {1'b1, 5'd16};  8'h2D: return {1'b1, 5'd17};
      8'h1B: return {1'b1, 5'd18};  8'h2C: return {1'b1, 5'd19};
      8'h3C: return {1'b1, 5'd20};  8'h2A: return {1'b1, 5'd21};
      8'h1D: return {1'b1, 5'd22};  8'h22: return {1'b1, 5'd23};
      8'h35: return {1'b1, 5'd24};  8'h1A: return {1'b1, 5'd25};
      default: return 6'd0;
    endcase
  endfunction

  // {hit, digit 0..9}
  function automatic logic [4:0] digit_lookup(input logic [7:0] code);
    case (code)
      8'h45: return {1'b1, 4'd0};  8'h16: return {1'b1, 4'd1};
      8'h1E: return {1'b1, 4'd2};  8'h26: return {1'b1, 4'd3};
      8'h25: return {1'b1, 4'd4};  8'h2E: return {1'b1, 4'd5};
      8'h36: return {1'b1, 4'd6};  8'h3D: return {1'b1, 4'd7};
      8'h3E: return {1'b1, 4'd8};  8'h46: return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [7:0] shifted_digit(input logic [3:0] d);
    case (d)
      4'd0: return 8'h29;  4'd1: return 8'h21;  4'd2: return 8'h40;
      4'd3: return 8'h23;  4'd4: return 8'h24;  4'd5: return 8'h25;
      4'd6: return 8'h5E;  4'd7: return 8'h26;  4'd8: return 8'h2A;
      default: return 8'h28;
    endcase
  endfunction

  // Synchronizers plus one extra stage of ps2_clk for falling-edge detection
  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_prev;
  logic       w_fall;
  logic       w_bit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], bus.ps2_clk};
      r_data_sync <= {r_data_sync[0], bus.ps2_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_sync[1];
  assign w_bit  = r_data_sync[1];

  logic [3:0]          r_bit_cnt;
  logic [7:0]          r_sr;
  logic                r_par;
  logic [c_IDLE_W-1:0] r_idle;
  logic                r_byte_valid;
  logic [7:0]          r_byte;
  logic                r_frame_err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bit_cnt    <= 4'd0;
      r_sr         <= 8'd0;
      r_par        <= 1'b0;
      r_idle       <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= 8'd0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_fall) begin
        r_idle <= '0;
        if (r_bit_cnt == 4'd0) begin
          if (!w_bit) r_bit_cnt <= 4'd1;
        end else if (r_bit_cnt <= 4'd8) begin
          r_sr      <= {w_bit, r_sr[7:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else if (r_bit_cnt == 4'd9) begin
          r_par     <= w_bit;
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else begin
          r_bit_cnt <= 4'd0;
          if (w_bit && (^{r_sr, r_par})) begin
            r_byte       <= r_sr;
            r_byte_valid <= 1'b1;
          end else begin
            r_frame_err  <= 1'b1;
          end
        end
      end else if (r_idle != c_TIMEOUT) begin
        r_idle <= r_idle + 1'b1;
      end else if (r_bit_cnt != 4'd0) begin
        r_bit_cnt <= 4'd0;
      end
    end
  end

  // Decoder and cursor state
  state_t     r_state, w_state_nxt;
  logic [4:0] r_row, w_row_nxt;
  logic [6:0] r_col, w_col_nxt;
  logic       r_shift, w_shift_nxt;
  logic       r_caps, w_caps_nxt;
  logic       r_caps_held, w_caps_held_nxt;
  logic       r_wr_en, w_wr_en_nxt;
  logic [4:0] r_wr_row, w_wr_row_nxt;
  logic [6:0] r_wr_col, w_wr_col_nxt;
  logic [7:0] r_wr_char, w_wr_char_nxt;

  logic [5:0] w_letter;
  logic [4:0] w_digit;
  logic [4:0] w_row_inc;
  logic       w_print_hit;
  logic [7:0] w_print_char;

  assign w_letter  = letter_lookup(r_byte);
  assign w_digit   = digit_lookup(r_byte);
  assign w_row_inc = (r_row == c_LAST_ROW) ? 5'd0 : r_row + 5'd1;

  always_comb begin
    w_print_hit  = 1'b0;
    w_print_char = 8'h00;
    if (w_letter[5]) begin
      w_print_hit  = 1'b1;
      w_print_char = ((r_shift ^ r_caps) ? 8'h41 : 8'h61) + {3'b000, w_letter[4:0]};
    end else if (w_digit[4]) begin
      w_print_hit  = 1'b1;
      w_print_char = r_shift ? shifted_digit(w_digit[3:0]) : 8'h30 + {4'h0, w_digit[3:0]};
    end else if (r_byte == 8'h29) begin
      w_print_hit  = 1'b1;
      w_print_char = 8'h20;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_row       <= 5'd0;
      r_col       <= 7'd0;
      r_shift     <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_row    <= 5'd0;
      r_wr_col    <= 7'd0;
      r_wr_char   <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_shift     <= w_shift_nxt;
      r_caps      <= w_caps_nxt;
      r_caps_held <= w_caps_held_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_row    <= w_wr_row_nxt;
      r_wr_col    <= w_wr_col_nxt;
      r_wr_char   <= w_wr_char_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_row_nxt       = r_row;
    w_col_nxt       = r_col;
    w_shift_nxt     = r_shift;
    w_caps_nxt      = r_caps;
    w_caps_held_nxt = r_caps_held;
    w_wr_en_nxt     = 1'b0;
    w_wr_row_nxt    = r_wr_row;
    w_wr_col_nxt    = r_wr_col;
    w_wr_char_nxt   = r_wr_char;
    if (r_byte_valid) begin
      unique case (r_state)
        S_IDLE: begin
          if (r_byte == 8'hE0) begin
            w_state_nxt = S_EXT;
          end else if (r_byte == 8'hF0) begin
            w_state_nxt = S_BRK;
          end else if (r_byte == 8'h12 || r_byte == 8'h59) begin
            w_shift_nxt = 1'b1;
          end else if (r_byte == 8'h58) begin
            // typematic repeats of caps must not toggle again until it is released
            if (!r_caps_held) w_caps_nxt = ~r_caps;
            w_caps_held_nxt = 1'b1;
          end else if (r_byte == 8'h5A) begin
            w_col_nxt = 7'd0;
            w_row_nxt = w_row_inc;
          end else if (r_byte == 8'h66) begin
            if (r_col != 7'd0) begin
              w_col_nxt = r_col - 7'd1;
            end else if (r_row != 5'd0) begin
              w_row_nxt = r_row - 5'd1;
              w_col_nxt = c_LAST_COL;
            end
            w_wr_en_nxt   = 1'b1;
            w_wr_row_nxt  = w_row_nxt;
            w_wr_col_nxt  = w_col_nxt;
            w_wr_char_nxt = 8'h20;
          end else if (w_print_hit) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_row_nxt  = r_row;
            w_wr_col_nxt  = r_col;
            w_wr_char_nxt = w_print_char;
            if (r_col == c_LAST_COL) begin
              w_col_nxt = 7'd0;
              w_row_nxt = w_row_inc;
            end else begin
              w_col_nxt = r_col + 7'd1;
            end
          end
        end
        S_EXT: begin
          if (r_byte == 8'hF0) begin
            w_state_nxt = S_EXT_BRK;
          end else begin
            w_state_nxt = S_IDLE;
            case (r_byte)
              8'h6B: if (r_col != 7'd0)       w_col_nxt = r_col - 7'd1;
              8'h74: if (r_col != c_LAST_COL) w_col_nxt = r_col + 7'd1;
              8'h75: if (r_row != 5'd0)       w_row_nxt = r_row - 5'd1;
              8'h72: if (r_row != c_LAST_ROW) w_row_nxt = r_row + 5'd1;
              default: ;
            endcase
          end
        end
        S_BRK: begin
          if (r_byte == 8'h12 || r_byte == 8'h59) w_shift_nxt = 1'b0;
          if (r_byte == 8'h58) w_caps_held_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
        S_EXT_BRK: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.wr_en     = r_wr_en;
  assign bus.wr_row    = r_wr_row;
  assign bus.wr_col    = r_wr_col;
  assign bus.wr_char   = r_wr_char;
  assign bus.cur_row   = r_row;
  assign bus.cur_col   = r_col;
  assign bus.caps      = r_caps;
  assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_text_cursor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ps2_text_cursor                                               |
// | Brief   : Directed and randomized keystroke bench with a grid-level model. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_ps2_text_cursor;
  localparam int ROWS    = 30;
  localparam int COLS    = 70;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ps2_text_cursor_if bus();

  ps2_text_cursor #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stop_at, wr_cnt, wr_at, err_cnt, err_at;
  logic [4:0] got_row;
  logic [6:0] got_col;
  logic [7:0] got_char;

  // Reference model: cursor as a linear cell index plus key-state flags
  int m_pos;
  bit m_ext, m_brk, m_shift, m_caps, m_held;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  string shifted = ")!@#$%^&*(";

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      wr_at    = cyc;
      got_row  = bus.wr_row;
      got_col  = bus.wr_col;
      got_char = bus.wr_char;
    end
    if (bus.frame_err === 1'b1) begin
      err_cnt++;
      err_at = cyc;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      tick(); tick();
      bus.ps2_clk = 1'b0;
      if (i == 10) stop_at = cyc;
      repeat (HALF) tick();
      bus.ps2_clk = 1'b1;
      repeat (HALF) tick();
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    wr_cnt = 0; err_cnt = 0; wr_at = -1; err_at = -1; stop_at = -100;
    send_bits({~bad_stop, (~^b) ^ bad_par, b, 1'b0}, 11);
    repeat (4) tick();
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    m_pos = 0; m_ext = 0; m_brk = 0; m_shift = 0; m_caps = 0; m_held = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit ew, output int er,
                            output int ec, output logic [7:0] ech);
    int row, col;
    ew = 0; er = 0; ec = 0; ech = 8'h00;
    row = m_pos / COLS;
    col = m_pos % COLS;
    if (m_brk) begin
      if (!m_ext) begin
        if (b == 8'h12 || b == 8'h59) m_shift = 0;
        if (b == 8'h58) m_held = 0;
      end
      m_brk = 0; m_ext = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (m_ext) begin
      case (b)
        8'h6B: if (col > 0) col--;
        8'h74: if (col < COLS - 1) col++;
        8'h75: if (row > 0) row--;
        8'h72: if (row < ROWS - 1) row++;
        default: ;
      endcase
      m_pos = row * COLS + col;
      m_ext = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'h12 || b == 8'h59) begin
      m_shift = 1;
    end else if (b == 8'h58) begin
      if (!m_held) m_caps = !m_caps;
      m_held = 1;
    end else if (b == 8'h5A) begin
      m_pos = ((row + 1) % ROWS) * COLS;
    end else if (b == 8'h66) begin
      if (m_pos > 0) m_pos--;
      ew = 1; er = m_pos / COLS; ec = m_pos % COLS; ech = 8'h20;
    end else begin
      for (int i = 0; i < 26; i++)
        if (letter_codes[i] == b) ech = 8'((m_shift ^ m_caps) ? 65 + i : 97 + i);
      for (int i = 0; i < 10; i++)
        if (digit_codes[i] == b) ech = m_shift ? shifted[i] : 8'(48 + i);
      if (b == 8'h29) ech = 8'h20;
      if (ech != 8'h00) begin
        ew = 1; er = row; ec = col;
        m_pos = (m_pos + 1) % (ROWS * COLS);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) tick();
    checks++; if ({bus.wr_en, bus.frame_err, bus.caps} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {bus.wr_en, bus.frame_err, bus.caps}); end
    checks++; if ({bus.wr_row, bus.wr_col, bus.wr_char} !== 20'h0) begin
      errors++; $display("FAIL reset_wr: got %h want 0", {bus.wr_row, bus.wr_col, bus.wr_char}); end
    checks++; if ({bus.cur_row, bus.cur_col} !== 12'h0) begin
      errors++; $display("FAIL reset_cursor: got %h want 0", {bus.cur_row, bus.cur_col}); end
    do_reset();
  endtask

  task automatic test_single_make();
    do_reset();
    key(8'h1C);
    checks++; if (wr_cnt !== 1) begin
      errors++; $display("FAIL make_pulses: got %0d want 1", wr_cnt); end
    checks++; if (wr_at - stop_at !== 4) begin
      errors++; $display("FAIL make_latency: got %0d want 4", wr_at - stop_at); end
    checks++; if ({got_row, got_col, got_char} !== {5'd0, 7'd0, 8'h61}) begin
      errors++; $display("FAIL make_write: got %h want %h", {got_row, got_col, got_char}, {5'd0, 7'd0, 8'h61}); end
    checks++; if ({bus.cur_row, bus.cur_col} !== {5'd0, 7'd1}) begin
      errors++; $display("FAIL make_cursor: got %0d,%0d want 0,1", bus.cur_row, bus.cur_col); end
    checks++; if ({bus.wr_en, bus.wr_char} !== {1'b0, 8'h61}) begin
      errors++; $display("FAIL make_hold: got %h want %h", {bus.wr_en, bus.wr_char}, {1'b0, 8'h61}); end
  endtask

  task automatic test_shift();
    do_reset();
    key(8'h12);
    key(8'h1C);
    checks++; if (wr_cnt !== 1 || {got_row, got_col, got_char} !== {5'd0, 7'd0, 8'h41}) begin
      errors++; $display("FAIL shift_upper: got %0d %h want 1 %h", wr_cnt, {got_row, got_col, got_char}, {5'd0, 7'd0, 8'h41}); end
    key(8'hF0); key(8'h1C); key(8'hF0); key(8'h12);
    checks++; if (wr_cnt !== 0) begin
      errors++; $display("FAIL break_write: got %0d want 0", wr_cnt); end
    key(8'h1C);
    checks++; if (wr_cnt !== 1 || {got_row, got_col, got_char} !== {5'd0, 7'd1, 8'h61}) begin
      errors++; $display("FAIL shift_release: got %0d %h want 1 %h", wr_cnt, {got_row, got_col, got_char}, {5'd0, 7'd1, 8'h61}); end
  endtask

  task automatic test_wrap_backspace();
    do_reset();
    repeat (69) key(8'h29);
    checks++; if ({bus.cur_row, bus.cur_col} !== {5'd0, 7'd69}) begin
      errors++; $display("FAIL fill_row: got %0d,%0d want 0,69", bus.cur_row, bus.cur_col); end
    key(8'h29);
    checks++; if ({got_row, got_col, got_char} !== {5'd0, 7'd69, 8'h20} || {bus.cur_row, bus.cur_col} !== {5'd1, 7'd0}) begin
      errors++; $display("FAIL col_wrap: got %h cur %0d,%0d want 0,69,20 cur 1,0", {got_row, got_col, got_char}, bus.cur_row, bus.cur_col); end
    key(8'h66);
    checks++; if (wr_cnt !== 1 || {got_row, got_col, got_char} !== {5'd0, 7'd69, 8'h20} || {bus.cur_row, bus.cur_col} !== {5'd0, 7'd69}) begin
      errors++; $display("FAIL bs_row: got %0d %h cur %0d,%0d want 1 0,69,20 cur 0,69", wr_cnt, {got_row, got_col, got_char}, bus.cur_row, bus.cur_col); end
    key(8'h5A);
    checks++; if (wr_cnt !== 0 || {bus.cur_row, bus.cur_col} !== {5'd1, 7'd0}) begin
      errors++; $display("FAIL enter: got %0d cur %0d,%0d want 0 cur 1,0", wr_cnt, bus.cur_row, bus.cur_col); end
    repeat (28) key(8'h5A);
    repeat (69) key(8'h29);
    checks++; if ({bus.cur_row, bus.cur_col} !== {5'd29, 7'd69}) begin
      errors++; $display("FAIL last_cell: got %0d,%0d want 29,69", bus.cur_row, bus.cur_col); end
    key(8'h29);
    checks++; if ({got_row, got_col} !== {5'd29, 7'd69} || {bus.cur_row, bus.cur_col} !== {5'd0, 7'd0}) begin
      errors++; $display("FAIL grid_wrap: got %0d,%0d cur %0d,%0d want 29,69 cur 0,0", got_row, got_col, bus.cur_row, bus.cur_col); end
    key(8'h66);
    checks++; if (wr_cnt !== 1 || {got_row, got_col, got_char} !== {5'd0, 7'd0, 8'h20} || {bus.cur_row, bus.cur_col} !== {5'd0, 7'd0}) begin
      errors++; $display("FAIL bs_origin: got %0d %h cur %0d,%0d want 1 0,0,20 cur 0,0", wr_cnt, {got_row, got_col, got_char}, bus.cur_row, bus.cur_col); end
  endtask

  task automatic test_caps();
    logic [4:0] exp_caps = 5'b00111;
    logic [7:0] seq [5] = '{8'h58, 8'h58, 8'h58, 8'hF0, 8'h58};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      key(seq[i]);
      if (i == 3) key(8'h58);
      checks++; if (bus.caps !== (i < 4 ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL caps_step%0d: got %b want %b", i, bus.caps, (i < 4 ? 1'b1 : 1'b0)); end
    end
    key(8'h1C);
    checks++; if (wr_cnt !== 1 || got_char !== 8'h61) begin
      errors++; $display("FAIL caps_off_char: got %0d %h want 1 61", wr_cnt, got_char); end
    exp_caps = {exp_caps[3:0], 1'b0};
  endtask

  task automatic test_arrows();
    logic [7:0] dir [4] = '{8'h6B, 8'h75, 8'h72, 8'h74};
    logic [11:0] exp [4] = '{{5'd0, 7'd0}, {5'd0, 7'd0}, {5'd1, 7'd0}, {5'd1, 7'd1}};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      key(8'hE0);
      key(dir[i]);
      checks++; if (wr_cnt !== 0 || {bus.cur_row, bus.cur_col} !== exp[i]) begin
        errors++; $display("FAIL arrow%0d: got %0d %h want 0 %h", i, wr_cnt, {bus.cur_row, bus.cur_col}, exp[i]); end
    end
  endtask

  task automatic test_errors();
    do_reset();
    send_frame(8'h1C, 1'b1, 1'b0);
    checks++; if (err_cnt !== 1 || err_at - stop_at !== 3 || wr_cnt !== 0) begin
      errors++; $display("FAIL bad_parity: got err %0d at %0d wr %0d want 1 at 3 wr 0", err_cnt, err_at - stop_at, wr_cnt); end
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (err_cnt !== 1 || wr_cnt !== 0 || {bus.cur_row, bus.cur_col} !== 12'h0) begin
      errors++; $display("FAIL bad_stop: got err %0d wr %0d want 1 0", err_cnt, wr_cnt); end
    send_bits({2'b11, 8'h3C, 1'b0}, 4);
    repeat (TIMEOUT + 50) tick();
    key(8'h45);
    checks++; if (wr_cnt !== 1 || {got_row, got_col, got_char} !== {5'd0, 7'd0, 8'h30}) begin
      errors++; $display("FAIL timeout_recover: got %0d %h want 1 %h", wr_cnt, {got_row, got_col, got_char}, {5'd0, 7'd0, 8'h30}); end
    key(8'h58); key(8'h1C);
    send_bits({2'b11, 8'h5A, 1'b0}, 5);
    reset = 1'b0;
    repeat (2) tick();
    checks++; if ({bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_char, bus.cur_row, bus.cur_col, bus.caps, bus.frame_err} !== 35'h0) begin
      errors++; $display("FAIL midframe_reset: got %h want 0", {bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_char, bus.cur_row, bus.cur_col, bus.caps, bus.frame_err}); end
    reset = 1'b1;
    repeat (2) tick();
    key(8'h1C);
    checks++; if (wr_cnt !== 1 || {got_row, got_col, got_char} !== {5'd0, 7'd0, 8'h61}) begin
      errors++; $display("FAIL after_reset: got %0d %h want 1 %h", wr_cnt, {got_row, got_col, got_char}, {5'd0, 7'd0, 8'h61}); end
  endtask

  task automatic test_random();
    logic [7:0] specials [8] = '{8'h12, 8'h59, 8'h58, 8'h29, 8'h5A, 8'h66, 8'h05, 8'h76};
    logic [7:0] arrows [4] = '{8'h6B, 8'h74, 8'h75, 8'h72};
    logic [7:0] seq [$];
    logic [7:0] code, ech;
    logic [4:0] lw_row;
    logic [6:0] lw_col;
    logic [7:0] lw_char;
    bit ew;
    int er, ec, kind;
    do_reset();
    lw_row = 0; lw_col = 0; lw_char = 0;
    for (int e = 0; e < 120; e++) begin
      seq.delete();
      kind = $urandom_range(0, 9);
      if (kind <= 3)      code = letter_codes[$urandom_range(0, 25)];
      else if (kind <= 5) code = digit_codes[$urandom_range(0, 9)];
      else if (kind <= 8) code = specials[$urandom_range(0, 7)];
      else                code = arrows[$urandom_range(0, 3)];
      if (kind == 9) begin
        seq.push_back(8'hE0);
        if ($urandom_range(0, 3) == 0) seq.push_back(8'hF0);
      end else if (kind == 8) begin
        seq.push_back(8'hF0);
      end
      seq.push_back(code);
      for (int k = 0; k < seq.size(); k++) begin
        model_byte(seq[k], ew, er, ec, ech);
        key(seq[k]);
        checks++; if (wr_cnt !== (ew ? 1 : 0)) begin
          errors++; $display("FAIL rnd_wr_count byte %h: got %0d want %0d", seq[k], wr_cnt, ew); end
        if (ew) begin
          checks++; if (wr_at - stop_at !== 4 || {got_row, got_col, got_char} !== {5'(er), 7'(ec), ech}) begin
            errors++; $display("FAIL rnd_write byte %h: got %h lat %0d want %h lat 4", seq[k], {got_row, got_col, got_char}, wr_at - stop_at, {5'(er), 7'(ec), ech}); end
          lw_row = 5'(er); lw_col = 7'(ec); lw_char = ech;
        end
        checks++; if ({bus.cur_row, bus.cur_col} !== {5'(m_pos / COLS), 7'(m_pos % COLS)}) begin
          errors++; $display("FAIL rnd_cursor byte %h: got %0d,%0d want %0d,%0d", seq[k], bus.cur_row, bus.cur_col, m_pos / COLS, m_pos % COLS); end
        checks++; if (bus.caps !== m_caps || err_cnt !== 0) begin
          errors++; $display("FAIL rnd_caps byte %h: got %b err %0d want %b err 0", seq[k], bus.caps, err_cnt, m_caps); end
        checks++; if ({bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_char} !== {1'b0, lw_row, lw_col, lw_char}) begin
          errors++; $display("FAIL rnd_hold byte %h: got %h want %h", seq[k], {bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_char}, {1'b0, lw_row, lw_col, lw_char}); end
      end
    end
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    test_reset();
    test_single_make();
    test_shift();
    test_wrap_backspace();
    test_caps();
    test_arrows();
    test_errors();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
